// File: rtl/cnn_pkg.sv
// Shared definitions for the patch scheduler: FSM state encoding and
// output-dimension helpers for a KxK / stride-S / pad-P window sweep.
package cnn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        EMIT  = 2'd3
    } state_t;

    function automatic int out_dim(input int h, input int p, input int k, input int s);
        return (h + 2 * p - k) / s + 1;
    endfunction

    function automatic int ctr_w(input int oh, input int ow);
        int mx;
        mx = (oh > ow) ? oh : ow;
        return (mx > 1) ? $clog2(mx) : 1;
    endfunction

endpackage

// File: rtl/patch_addr_gen.sv
// Combinational mapping from (output row i, output column j, element e)
// to the image coordinate's in-range flag and its memory address x*W+y.
module patch_addr_gen
    import cnn_pkg::*;
#(
    parameter int H      = 5,
    parameter int W      = 5,
    parameter int K      = 3,
    parameter int S      = 1,
    parameter int P      = 1,
    parameter int ADDR_W = 5,
    parameter int CW     = 3,
    parameter int EW     = 4
) (
    input  logic [CW-1:0]     i,
    input  logic [CW-1:0]     j,
    input  logic [EW-1:0]     e,
    output logic              in_range,
    output logic [ADDR_W-1:0] addr
);

    // Headroom so that negative padded offsets and stride products never wrap.
    localparam int XW = ADDR_W + CW + EW + $clog2(S + 1) + 2;

    logic [EW-1:0]        m;
    logic [EW-1:0]        n;
    logic signed [XW-1:0] x;
    logic signed [XW-1:0] y;

    always_comb begin
        m        = e / EW'(K);
        n        = e % EW'(K);
        x        = XW'(i) * XW'(S) - XW'(P) + XW'(m);
        y        = XW'(j) * XW'(S) - XW'(P) + XW'(n);
        in_range = !x[XW-1] && (x < XW'(H)) && !y[XW-1] && (y < XW'(W));
        addr     = '0;
        if (in_range) begin
            addr = ADDR_W'(x * XW'(W) + y);
        end
    end

endmodule

// File: rtl/patch_scheduler.sv
// Sweeps every KxK window position over an HxW binary image, fetching one pixel
// per cycle and handing each patch out over valid/ready. Optional read
// statistics counter enabled by defining PATCH_SCHED_STATS_EN.
module patch_scheduler
    import cnn_pkg::*;
#(
    parameter int H      = 5,
    parameter int W      = 5,
    parameter int K      = 3,
    parameter int S      = 1,
    parameter int P      = 1,
    parameter int ADDR_W = 5,
    localparam int OH    = out_dim(H, P, K, S),
    localparam int OW    = out_dim(W, P, K, S),
    localparam int CW    = ctr_w(OH, OW)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_pixel,
    output logic [K*K-1:0]    patch,
    output logic              patch_valid,
    input  logic              patch_ready,
    output logic [CW-1:0]     patch_i,
    output logic [CW-1:0]     patch_j,
    output logic              patch_last,
    output logic [15:0]       rd_count
);

    localparam int NE = K * K;
    localparam int EW = (NE > 1) ? $clog2(NE) : 1;

    state_t            state;
    logic [CW-1:0]     i;
    logic [CW-1:0]     j;
    logic [EW-1:0]     e;
    logic [EW-1:0]     e_d;
    logic              rd_d;
    logic [ADDR_W-1:0] addr_q;
    logic              in_range;
    logic [ADDR_W-1:0] gen_addr;
    logic              last_pos;

    patch_addr_gen #(
        .H      (H),
        .W      (W),
        .K      (K),
        .S      (S),
        .P      (P),
        .ADDR_W (ADDR_W),
        .CW     (CW),
        .EW     (EW)
    ) u_addr_gen (
        .i        (i),
        .j        (j),
        .e        (e),
        .in_range (in_range),
        .addr     (gen_addr)
    );

    assign last_pos    = (i == CW'(OH - 1)) && (j == CW'(OW - 1));
    assign busy        = (state != IDLE);
    assign patch_valid = (state == EMIT);
    assign patch_last  = patch_valid && last_pos;
    assign patch_i     = i;
    assign patch_j     = j;
    assign mem_rd      = (state == FETCH) && in_range;
    // Address holds its previous value across padded elements.
    assign mem_addr    = mem_rd ? gen_addr : addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            i      <= '0;
            j      <= '0;
            e      <= '0;
            e_d    <= '0;
            rd_d   <= 1'b0;
            addr_q <= '0;
            patch  <= '0;
            done   <= 1'b0;
        end else begin
            done   <= 1'b0;
            rd_d   <= mem_rd;
            e_d    <= e;
            addr_q <= mem_addr;
            // Read data lands one cycle after the strobe; file it under the element that asked.
            if (rd_d) begin
                patch[e_d] <= mem_pixel;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= FETCH;
                        i     <= '0;
                        j     <= '0;
                        e     <= '0;
                    end
                end
                FETCH: begin
                    if (!in_range) begin
                        patch[e] <= 1'b0;
                    end
                    if (e == EW'(NE - 1)) begin
                        e     <= '0;
                        state <= DRAIN;
                    end else begin
                        e <= e + EW'(1);
                    end
                end
                DRAIN: begin
                    state <= EMIT;
                end
                EMIT: begin
                    if (patch_ready) begin
                        if (last_pos) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            state <= FETCH;
                            if (j == CW'(OW - 1)) begin
                                j <= '0;
                                i <= i + CW'(1);
                            end else begin
                                j <= j + CW'(1);
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PATCH_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && start)) begin
            rd_count <= '0;
        end else if (mem_rd && rd_count != 16'hFFFF) begin
            rd_count <= rd_count + 16'd1;
        end
    end
`else
    assign rd_count = '0;
`endif

endmodule

// File: tb/tb_patch_scheduler.sv
// Self-checking bench for patch_scheduler (H=W=5, K=3, S=1, P=1, pixel[a]=a[0]).
module tb_patch_scheduler;

    localparam int H      = 5;
    localparam int W      = 5;
    localparam int K      = 3;
    localparam int S      = 1;
    localparam int P      = 1;
    localparam int ADDR_W = 5;
    localparam int OH     = 5;
    localparam int OW     = 5;
    localparam int CW     = 3;
    localparam int NE     = K * K;
`ifdef PATCH_SCHED_STATS_EN
    localparam bit STATS  = 1'b1;
`else
    localparam bit STATS  = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              busy;
    logic              done;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_pixel;
    logic [NE-1:0]     patch;
    logic              patch_valid;
    logic              patch_ready;
    logic [CW-1:0]     patch_i;
    logic [CW-1:0]     patch_j;
    logic              patch_last;
    logic [15:0]       rd_count;

    always #5 clk = ~clk;

    patch_scheduler #(
        .H(H), .W(W), .K(K), .S(S), .P(P), .ADDR_W(ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_pixel   (mem_pixel),
        .patch       (patch),
        .patch_valid (patch_valid),
        .patch_ready (patch_ready),
        .patch_i     (patch_i),
        .patch_j     (patch_j),
        .patch_last  (patch_last),
        .rd_count    (rd_count)
    );

    // Image memory: one-cycle read latency, junk on the bus when not reading.
    always @(posedge clk) begin
        mem_pixel <= mem_rd ? mem_addr[0] : 1'($urandom);
    end

    typedef struct {
        int            i;
        int            j;
        logic [NE-1:0] patch;
        logic          last;
    } exp_t;

    exp_t              sb[$];
    int                checks = 0;
    int                errors = 0;
    int                reads_seen = 0;
    int                done_seen = 0;
    int                hs_count = 0;
    logic [ADDR_W-1:0] rd_log[$];
    logic [NE-1:0]     cap_patch[OH*OW];
    logic              cap_last[OH*OW];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic void model(input int i, input int j, output logic [NE-1:0] p, output int nrd);
        int x, y;
        p   = '0;
        nrd = 0;
        for (int m = 0; m < K; m++) begin
            for (int n = 0; n < K; n++) begin
                x = i * S - P + m;
                y = j * S - P + n;
                if (x >= 0 && x < H && y >= 0 && y < W) begin
                    p[m*K+n] = ((x * W + y) % 2) == 1;
                    nrd++;
                end
            end
        end
    endfunction

    always @(negedge clk) begin
        exp_t ex;
        int   idx;
        if (mem_rd) begin
            reads_seen++;
            if (rd_log.size() < 4) rd_log.push_back(mem_addr);
            chk("rd_addr_range", 32'(mem_addr <= ADDR_W'(H * W - 1)), 1);
        end
        if (done) done_seen++;
        if (patch_valid && patch_ready) begin
            hs_count++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL hs_unexpected actual=(%0d,%0d) required=none", patch_i, patch_j);
            end else begin
                ex = sb.pop_front();
                chk("hs_i", patch_i, ex.i);
                chk("hs_j", patch_j, ex.j);
                chk("hs_patch", patch, ex.patch);
                chk("hs_last", patch_last, ex.last);
            end
            idx = int'(patch_i) * OW + int'(patch_j);
            if (idx < OH * OW) begin
                cap_patch[idx] = patch;
                cap_last[idx]  = patch_last;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_mem_rd"}, mem_rd, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_patch"}, patch, 0);
        chk({tag, "_valid"}, patch_valid, 0);
        chk({tag, "_i"}, patch_i, 0);
        chk({tag, "_j"}, patch_j, 0);
        chk({tag, "_last"}, patch_last, 0);
        chk({tag, "_rd_count"}, rd_count, 0);
    endtask

    task automatic push_expected(output int exp_reads);
        logic [NE-1:0] p;
        int            nrd;
        exp_reads = 0;
        for (int i = 0; i < OH; i++) begin
            for (int j = 0; j < OW; j++) begin
                model(i, j, p, nrd);
                exp_reads += nrd;
                sb.push_back('{i, j, p, (i == OH - 1) && (j == OW - 1)});
            end
        end
    endtask

    task automatic stall_hold();
        logic [NE-1:0] sp;
        logic [CW-1:0] si, sj;
        logic          sl;
        bit            stable, nord;
        int            w;
        patch_ready = 1'b0;
        w = 0;
        while (!patch_valid && w < 40) begin
            tick();
            w++;
        end
        chk("stall_reached_valid", patch_valid, 1);
        sp = patch; si = patch_i; sj = patch_j; sl = patch_last;
        stable = 1'b1;
        nord   = 1'b1;
        repeat (20) begin
            tick();
            if (!patch_valid || patch !== sp || patch_i !== si || patch_j !== sj || patch_last !== sl)
                stable = 1'b0;
            if (mem_rd) nord = 1'b0;
        end
        chk("stall_stable", stable, 1);
        chk("stall_no_rd", nord, 1);
        chk("stall_ij", {si, sj}, {3'd2, 3'd3});
        chk("stall_patch", sp, 9'b101_010_101);
        patch_ready = 1'b1;
    endtask

    task automatic sweep(input bit stall, input bit poke, input string tag);
        int n, t_valid, t_done, rds_at_valid, exp_reads;
        bit stalled;
        int first_addr[4] = '{0, 1, 5, 6};
        push_expected(exp_reads);
        reads_seen = 0; done_seen = 0; hs_count = 0;
        rd_log.delete();
        t_valid = -1; t_done = -1; rds_at_valid = -1; stalled = 1'b0;
        patch_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy_start"}, busy, 1);
        n = 0;
        while (t_done < 0 && n < 1000) begin
            start = poke && (n == 30 || n == 100 || n == 200);
            tick();
            n++;
            if (t_valid < 0 && patch_valid) begin
                t_valid      = n;
                rds_at_valid = reads_seen;
            end
            if (done) t_done = n;
            if (stall && !stalled && busy && !patch_valid && patch_i == 2 && patch_j == 3) begin
                stalled = 1'b1;
                stall_hold();
            end
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, 32'(t_done >= 0), 1);
        if (!stall) chk({tag, "_done_time"}, t_done, OH * OW * (NE + 2));
        chk({tag, "_valid_time"}, t_valid, NE + 1);
        chk({tag, "_first_reads"}, rds_at_valid, 4);
        for (int k = 0; k < 4; k++) begin
            chk({tag, "_first_addr"}, (k < rd_log.size()) ? 32'(rd_log[k]) : 32'hFFFF_FFFF, first_addr[k]);
        end
        tick();
        chk({tag, "_done_once"}, done_seen, 1);
        chk({tag, "_done_low"}, done, 0);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_hs_count"}, hs_count, OH * OW);
        chk({tag, "_sb_empty"}, sb.size(), 0);
        chk({tag, "_reads_total"}, reads_seen, exp_reads);
        chk({tag, "_rd_count"}, rd_count, STATS ? exp_reads : 0);
    endtask

    task automatic table_check(input string tag);
        exp_t tbl[7];
        int   idx;
        tbl[0] = '{0, 0, 9'b010_100_000, 1'b0};
        tbl[1] = '{0, 4, 9'b010_001_000, 1'b0};
        tbl[2] = '{4, 0, 9'b000_100_010, 1'b0};
        tbl[3] = '{1, 1, 9'b010_101_010, 1'b0};
        tbl[4] = '{2, 2, 9'b010_101_010, 1'b0};
        tbl[5] = '{2, 3, 9'b101_010_101, 1'b0};
        tbl[6] = '{4, 4, 9'b000_001_010, 1'b1};
        for (int k = 0; k < 7; k++) begin
            idx = tbl[k].i * OW + tbl[k].j;
            chk({tag, "_tbl_patch"}, cap_patch[idx], tbl[k].patch);
            chk({tag, "_tbl_last"}, cap_last[idx], tbl[k].last);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int dummy;
        rst = 1'b1; start = 1'b0; patch_ready = 1'b0;
        for (int k = 0; k < OH * OW; k++) begin
            cap_patch[k] = 'x;
            cap_last[k]  = 1'bx;
        end
        repeat (3) tick();
        check_zero("rst");
        rst = 1'b0;
        tick();
        check_zero("idle");

        // Ready high with nothing valid must not produce handshakes.
        hs_count = 0;
        patch_ready = 1'b1;
        repeat (5) tick();
        chk("idle_ready_hs", hs_count, 0);
        chk("idle_ready_busy", busy, 0);

        sweep(1'b0, 1'b0, "clean");
        table_check("clean");

        sweep(1'b1, 1'b0, "stall");

        // Abort mid-FETCH of patch (1,1).
        sb.delete();
        push_expected(dummy);
        patch_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        done_seen = 0;
        w = 0;
        while (!(busy && !patch_valid && patch_i == 1 && patch_j == 1) && w < 400) begin
            tick();
            w++;
        end
        chk("abort_reached", 32'(busy && patch_i == 1 && patch_j == 1), 1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_zero("abort");
        rst = 1'b0;
        sb.delete();
        tick();
        check_zero("abort_idle");
        chk("abort_no_done", done_seen, 0);

        for (int k = 0; k < OH * OW; k++) cap_patch[k] = 'x;
        sweep(1'b0, 1'b1, "poke");
        table_check("poke");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
